// File: rtl/rob_pkg.sv
// Shared types and default sizing for the N-way reorder buffer.
// Holds the default parameter constants, the per-entry status flags, the
// full entry record and the dispatch / completion / retire packet layouts
// (payload widths follow the default AREG/PREG widths).
package rob_pkg;

  localparam int unsigned ROB_SIZE_DEF = 16;
  localparam int unsigned WAYS_DEF     = 2;
  localparam int unsigned AREG_W_DEF   = 5;
  localparam int unsigned PREG_W_DEF   = 6;
  localparam int unsigned IDX_W_DEF    = $clog2(ROB_SIZE_DEF);

  // Status bits kept per entry; the only part the retire chain looks at.
  typedef struct packed {
    logic valid;
    logic complete;
    logic mispred;
  } rob_flags_t;

  // One ROB entry.
  typedef struct packed {
    rob_flags_t              flags;
    logic [AREG_W_DEF-1:0]   areg;
    logic [PREG_W_DEF-1:0]   preg;
    logic [PREG_W_DEF-1:0]   told;
  } rob_entry_t;

  // One dispatch way.
  typedef struct packed {
    logic                    valid;
    logic [AREG_W_DEF-1:0]   areg;
    logic [PREG_W_DEF-1:0]   preg;
    logic [PREG_W_DEF-1:0]   told;
  } dp_pkt_t;

  // One completion broadcast way.
  typedef struct packed {
    logic                    valid;
    logic [IDX_W_DEF-1:0]    rob_idx;
    logic                    mispred;
  } cdb_pkt_t;

  // One retire way.
  typedef struct packed {
    logic                    valid;
    logic [AREG_W_DEF-1:0]   areg;
    logic [PREG_W_DEF-1:0]   preg;
    logic [PREG_W_DEF-1:0]   told;
  } rt_pkt_t;

endpackage

// File: rtl/rob_retire_sel.sv
// Retire selection over the head window of the ROB.
// Ports:
//   en_i       - retirement allowed this cycle (low during reset)
//   win_i      - status flags of entries head+0 .. head+WAYS-1
//   rt_valid_o - way k retires (contiguous from way 0)
//   flush_o    - a retiring entry carries a misprediction
module rob_retire_sel
  import rob_pkg::*;
#(
  parameter int unsigned WAYS = WAYS_DEF
) (
  input  logic                   en_i,
  input  rob_flags_t [WAYS-1:0]  win_i,
  output logic [WAYS-1:0]        rt_valid_o,
  output logic                   flush_o
);

  logic chain_ok;

  // Prefix chain: a way retires only if every older way retired cleanly.
  always_comb begin
    rt_valid_o = '0;
    flush_o    = 1'b0;
    chain_ok   = en_i;
    for (int k = 0; k < int'(WAYS); k++) begin
      rt_valid_o[k] = chain_ok & win_i[k].valid & win_i[k].complete;
      flush_o       = flush_o | (rt_valid_o[k] & win_i[k].mispred);
      chain_ok      = rt_valid_o[k] & ~win_i[k].mispred;
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer: in-order dispatch, out-of-order completion,
// in-order retirement of up to WAYS entries per cycle, flush on a retiring
// mispredicted entry.
// Ports:
//   clk_i, rst_ni                         - clock, synchronous active-low reset
//   dp_valid_i/areg_i/preg_i/told_i       - dispatch requests per way
//   dp_free_o                             - registered free entry count
//   dp_rob_idx_o                          - index assigned to each dispatch way
//   cdb_valid_i/rob_idx_i/mispred_i       - completion broadcast per way
//   rt_valid_o/areg_o/preg_o/told_o       - retiring entries per way
//   flush_o                               - mispredicted entry retiring
module rob_nway
  import rob_pkg::*;
#(
  parameter  int unsigned ROB_SIZE = ROB_SIZE_DEF,
  parameter  int unsigned WAYS     = WAYS_DEF,
  parameter  int unsigned AREG_W   = AREG_W_DEF,
  parameter  int unsigned PREG_W   = PREG_W_DEF,
  localparam int unsigned IDX_W    = $clog2(ROB_SIZE),
  localparam int unsigned CNT_W    = IDX_W + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [WAYS-1:0]         dp_valid_i,
  input  logic [WAYS*AREG_W-1:0]  dp_areg_i,
  input  logic [WAYS*PREG_W-1:0]  dp_preg_i,
  input  logic [WAYS*PREG_W-1:0]  dp_told_i,
  output logic [CNT_W-1:0]        dp_free_o,
  output logic [WAYS*IDX_W-1:0]   dp_rob_idx_o,
  input  logic [WAYS-1:0]         cdb_valid_i,
  input  logic [WAYS*IDX_W-1:0]   cdb_rob_idx_i,
  input  logic [WAYS-1:0]         cdb_mispred_i,
  output logic [WAYS-1:0]         rt_valid_o,
  output logic [WAYS*AREG_W-1:0]  rt_areg_o,
  output logic [WAYS*PREG_W-1:0]  rt_preg_o,
  output logic [WAYS*PREG_W-1:0]  rt_told_o,
  output logic                    flush_o
);

  rob_flags_t [ROB_SIZE-1:0] flags_q, flags_d;
  logic [AREG_W-1:0]         areg_q [ROB_SIZE];
  logic [AREG_W-1:0]         areg_d [ROB_SIZE];
  logic [PREG_W-1:0]         preg_q [ROB_SIZE];
  logic [PREG_W-1:0]         preg_d [ROB_SIZE];
  logic [PREG_W-1:0]         told_q [ROB_SIZE];
  logic [PREG_W-1:0]         told_d [ROB_SIZE];
  logic [IDX_W-1:0]          head_q, head_d;
  logic [IDX_W-1:0]          tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [CNT_W-1:0]          free_q, free_d;

  rob_flags_t [WAYS-1:0]     win;
  logic [WAYS-1:0]           dp_room;
  logic [WAYS-1:0]           dp_acc;
  logic                      flush_c;
  logic [CNT_W-1:0]          n_rt;
  logic [CNT_W-1:0]          n_dp;

  // Head window view and dispatch index outputs.
  always_comb begin
    win          = '0;
    rt_areg_o    = '0;
    rt_preg_o    = '0;
    rt_told_o    = '0;
    dp_rob_idx_o = '0;
    for (int k = 0; k < int'(WAYS); k++) begin
      win[k]                             = flags_q[IDX_W'(head_q + IDX_W'(k))];
      rt_areg_o[k*AREG_W +: AREG_W]      = areg_q[IDX_W'(head_q + IDX_W'(k))];
      rt_preg_o[k*PREG_W +: PREG_W]      = preg_q[IDX_W'(head_q + IDX_W'(k))];
      rt_told_o[k*PREG_W +: PREG_W]      = told_q[IDX_W'(head_q + IDX_W'(k))];
      dp_rob_idx_o[k*IDX_W +: IDX_W]     = IDX_W'(tail_q + IDX_W'(k));
    end
  end

  rob_retire_sel #(
    .WAYS (WAYS)
  ) u_retire_sel (
    .en_i       (rst_ni),
    .win_i      (win),
    .rt_valid_o (rt_valid_o),
    .flush_o    (flush_c)
  );

  assign flush_o   = flush_c;
  assign dp_free_o = free_q;

  // Ways beyond the registered free count are dropped, not stored.
  always_comb begin
    dp_room = '0;
    dp_acc  = '0;
    for (int k = 0; k < int'(WAYS); k++) begin
      dp_room[k] = (CNT_W'(k) < free_q);
      dp_acc[k]  = dp_valid_i[k] & dp_room[k] & rst_ni & ~flush_c;
    end
  end

  // Next-state: completion, retirement, dispatch; flush overrides all.
  always_comb begin
    flags_d = flags_q;
    areg_d  = areg_q;
    preg_d  = preg_q;
    told_d  = told_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    free_d  = free_q;
    n_rt    = '0;
    n_dp    = '0;
    if (flush_c) begin
      flags_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      free_d  = CNT_W'(ROB_SIZE);
    end else begin
      for (int w = 0; w < int'(WAYS); w++) begin
        if (cdb_valid_i[w] && flags_q[cdb_rob_idx_i[w*IDX_W +: IDX_W]].valid) begin
          flags_d[cdb_rob_idx_i[w*IDX_W +: IDX_W]].complete = 1'b1;
          flags_d[cdb_rob_idx_i[w*IDX_W +: IDX_W]].mispred  =
            flags_d[cdb_rob_idx_i[w*IDX_W +: IDX_W]].mispred | cdb_mispred_i[w];
        end
      end
      for (int k = 0; k < int'(WAYS); k++) begin
        if (rt_valid_o[k]) begin
          flags_d[IDX_W'(head_q + IDX_W'(k))].valid = 1'b0;
          n_rt = n_rt + CNT_W'(1);
        end
      end
      for (int k = 0; k < int'(WAYS); k++) begin
        if (dp_acc[k]) begin
          flags_d[IDX_W'(tail_q + IDX_W'(k))] = '{valid: 1'b1, complete: 1'b0, mispred: 1'b0};
          areg_d[IDX_W'(tail_q + IDX_W'(k))]  = dp_areg_i[k*AREG_W +: AREG_W];
          preg_d[IDX_W'(tail_q + IDX_W'(k))]  = dp_preg_i[k*PREG_W +: PREG_W];
          told_d[IDX_W'(tail_q + IDX_W'(k))]  = dp_told_i[k*PREG_W +: PREG_W];
          n_dp = n_dp + CNT_W'(1);
        end
      end
      head_d  = IDX_W'(head_q + IDX_W'(n_rt));
      tail_d  = IDX_W'(tail_q + IDX_W'(n_dp));
      count_d = count_q + n_dp - n_rt;
      // Slots freed by this cycle's retirement show up one cycle later.
      free_d  = CNT_W'(ROB_SIZE) - count_d;
    end
  end

  // State register; payload needs no reset since validity gates its use.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flags_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= CNT_W'(ROB_SIZE);
    end else begin
      flags_q <= flags_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
    end
    areg_q <= areg_d;
    preg_q <= preg_d;
    told_q <= told_d;
  end

  // Dispatcher must never request more ways than there are free slots.
  dp_overrun_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
    flush_c || ((dp_valid_i & ~dp_room) == '0))
    else $warning("rob_nway: dispatch request beyond free slots dropped");

endmodule

// File: tb/tb_rob_nway.sv
module tb_rob_nway;
  import rob_pkg::*;

  localparam int unsigned ROB = 16;
  localparam int unsigned W   = 2;
  localparam int unsigned AW  = 5;
  localparam int unsigned PW  = 6;
  localparam int unsigned IW  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W-1:0]    dp_valid;
  logic [W*AW-1:0] dp_areg;
  logic [W*PW-1:0] dp_preg, dp_told;
  logic [IW:0]     dp_free;
  logic [W*IW-1:0] dp_rob_idx;
  logic [W-1:0]    cdb_valid, cdb_mispred;
  logic [W*IW-1:0] cdb_idx;
  logic [W-1:0]    rt_valid;
  logic [W*AW-1:0] rt_areg;
  logic [W*PW-1:0] rt_preg, rt_told;
  logic            flush;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rob_nway #(.ROB_SIZE(ROB), .WAYS(W), .AREG_W(AW), .PREG_W(PW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dp_valid_i(dp_valid), .dp_areg_i(dp_areg), .dp_preg_i(dp_preg), .dp_told_i(dp_told),
    .dp_free_o(dp_free), .dp_rob_idx_o(dp_rob_idx),
    .cdb_valid_i(cdb_valid), .cdb_rob_idx_i(cdb_idx), .cdb_mispred_i(cdb_mispred),
    .rt_valid_o(rt_valid), .rt_areg_o(rt_areg), .rt_preg_o(rt_preg), .rt_told_o(rt_told),
    .flush_o(flush)
  );

  // Reference model: program-ordered queue of in-flight entries.
  typedef struct { int idx; rob_entry_t e; } ment_t;
  ment_t           mq[$];
  int              m_tail = 0;
  logic [W-1:0]    exp_rt;
  logic            exp_flush;
  int              exp_free;
  logic [W*AW-1:0] exp_areg;
  logic [W*PW-1:0] exp_preg, exp_told;
  logic [W*IW-1:0] exp_idx;

  task automatic model_expect();
    exp_rt = '0; exp_flush = 1'b0;
    exp_areg = '0; exp_preg = '0; exp_told = '0;
    for (int k = 0; k < int'(W); k++) begin
      if (!rst_n || k >= mq.size()) break;
      if (!mq[k].e.flags.complete) break;
      exp_rt[k] = 1'b1;
      exp_areg[k*AW +: AW] = mq[k].e.areg;
      exp_preg[k*PW +: PW] = mq[k].e.preg;
      exp_told[k*PW +: PW] = mq[k].e.told;
      if (mq[k].e.flags.mispred) begin exp_flush = 1'b1; break; end
    end
    exp_free = int'(ROB) - mq.size();
    for (int k = 0; k < int'(W); k++) exp_idx[k*IW +: IW] = IW'(m_tail + k);
  endtask

  task automatic model_step();
    int free0;
    model_expect();
    if (!rst_n || exp_flush) begin mq.delete(); m_tail = 0; return; end
    free0 = int'(ROB) - mq.size();
    for (int w = 0; w < int'(W); w++)
      if (cdb_valid[w])
        foreach (mq[i])
          if (mq[i].idx == int'(cdb_idx[w*IW +: IW])) begin
            mq[i].e.flags.complete = 1'b1;
            mq[i].e.flags.mispred  = mq[i].e.flags.mispred | cdb_mispred[w];
          end
    for (int k = 0; k < int'(W); k++) if (exp_rt[k]) void'(mq.pop_front());
    for (int k = 0; k < int'(W); k++) begin
      if (dp_valid[k] && k < free0) begin
        ment_t m;
        m.idx = m_tail;
        m.e = '0;
        m.e.flags.valid = 1'b1;
        m.e.areg = dp_areg[k*AW +: AW];
        m.e.preg = dp_preg[k*PW +: PW];
        m.e.told = dp_told[k*PW +: PW];
        mq.push_back(m);
        m_tail = (m_tail + 1) % int'(ROB);
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic set_dp(input int n, input int a0, input int p0);
    dp_valid = '0; dp_areg = '0; dp_preg = '0; dp_told = '0;
    for (int k = 0; k < n && k < int'(W); k++) begin
      dp_valid[k] = 1'b1;
      dp_areg[k*AW +: AW] = AW'(a0 + k);
      dp_preg[k*PW +: PW] = PW'(p0 + k);
      dp_told[k*PW +: PW] = PW'(p0 + k + 7);
    end
  endtask

  task automatic set_cdb(input logic [W-1:0] v, input int i0, input int i1, input logic [W-1:0] m);
    cdb_valid = v; cdb_idx = {IW'(i1), IW'(i0)}; cdb_mispred = m;
  endtask

  task automatic idle();
    set_dp(0, 0, 0); set_cdb('0, 0, 0, '0);
  endtask

  task automatic do_reset();
    idle(); rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      dp_valid = W'($urandom); dp_areg = W*AW'($urandom); dp_preg = W*PW'($urandom);
      dp_told = W*PW'($urandom); cdb_valid = W'($urandom); cdb_idx = W*IW'($urandom);
      cdb_mispred = W'($urandom);
      cyc();
      n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rt_valid: got %b want 00", rt_valid); end
      n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", flush); end
      n_cmp++; if (dp_free !== 5'd16) begin n_bad++; $display("FAIL reset_free: got %0d want 16", dp_free); end
      n_cmp++; if (dp_rob_idx !== 8'h10) begin n_bad++; $display("FAIL reset_idx: got %h want 10", dp_rob_idx); end
    end
    idle(); rst_n = 1'b1;
  endtask

  task automatic test_dispatch();
    set_dp(2, 3, 33);
    n_cmp++; if (dp_rob_idx !== 8'h10) begin n_bad++; $display("FAIL dp_idx: got %h want 10", dp_rob_idx); end
    n_cmp++; if (dp_free !== 5'd16) begin n_bad++; $display("FAIL dp_free_before: got %0d want 16", dp_free); end
    cyc(); idle();
    n_cmp++; if (dp_free !== 5'd14) begin n_bad++; $display("FAIL dp_free_after: got %0d want 14", dp_free); end
  endtask

  task automatic test_ooo_complete();
    set_cdb(2'b01, 1, 0, 2'b00); cyc(); idle();
    n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL ooo_no_retire: got %b want 00", rt_valid); end
    set_cdb(2'b01, 0, 0, 2'b00); cyc(); idle();
    n_cmp++; if (rt_valid !== 2'b11) begin n_bad++; $display("FAIL ooo_retire: got %b want 11", rt_valid); end
    n_cmp++; if (rt_preg !== {6'd34, 6'd33}) begin n_bad++; $display("FAIL ooo_preg: got %h want %h", rt_preg, {6'd34, 6'd33}); end
    n_cmp++; if (rt_areg !== {5'd4, 5'd3}) begin n_bad++; $display("FAIL ooo_areg: got %h want %h", rt_areg, {5'd4, 5'd3}); end
    cyc();
    n_cmp++; if (dp_free !== 5'd16) begin n_bad++; $display("FAIL ooo_free: got %0d want 16", dp_free); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin set_dp(2, i, 2*i + 10); cyc(); end
    idle();
    n_cmp++; if (dp_free !== 5'd0) begin n_bad++; $display("FAIL full_free: got %0d want 0", dp_free); end
    set_dp(2, 0, 63); cyc(); idle();
    n_cmp++; if (dp_free !== 5'd0) begin n_bad++; $display("FAIL full_drop_free: got %0d want 0", dp_free); end
    set_cdb(2'b11, 0, 1, 2'b00); cyc(); idle();
    n_cmp++; if (rt_valid !== 2'b11) begin n_bad++; $display("FAIL full_rt: got %b want 11", rt_valid); end
    n_cmp++; if (rt_preg !== {6'd11, 6'd10}) begin n_bad++; $display("FAIL full_preg: got %h want %h", rt_preg, {6'd11, 6'd10}); end
    n_cmp++; if (dp_free !== 5'd0) begin n_bad++; $display("FAIL full_free_same: got %0d want 0", dp_free); end
    cyc();
    n_cmp++; if (dp_free !== 5'd2) begin n_bad++; $display("FAIL full_free_next: got %0d want 2", dp_free); end
  endtask

  task automatic test_wrap();
    logic [PW-1:0] p0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      set_dp(1, 1, i); cyc(); idle();
      set_cdb(2'b01, i, 0, 2'b00); cyc(); idle(); cyc();
    end
    n_cmp++; if (dp_rob_idx !== {4'd0, 4'd15}) begin n_bad++; $display("FAIL wrap_idx: got %h want 0f", dp_rob_idx); end
    set_dp(2, 7, 50); cyc(); idle();
    set_cdb(2'b11, 15, 0, 2'b00); cyc(); idle();
    n_cmp++; if (rt_valid !== 2'b11) begin n_bad++; $display("FAIL wrap_rt: got %b want 11", rt_valid); end
    n_cmp++; if (rt_preg !== {6'd51, 6'd50}) begin n_bad++; $display("FAIL wrap_preg: got %h want %h", rt_preg, {6'd51, 6'd50}); end
    cyc();
    n_cmp++; if (dp_rob_idx !== {4'd2, 4'd1}) begin n_bad++; $display("FAIL wrap_tail: got %h want 21", dp_rob_idx); end
    set_dp(1, 9, 52); cyc(); idle();
    set_cdb(2'b01, 1, 0, 2'b00); cyc(); idle();
    p0 = rt_preg[PW-1:0];
    n_cmp++; if (rt_valid !== 2'b01) begin n_bad++; $display("FAIL wrap_head_rt: got %b want 01", rt_valid); end
    n_cmp++; if (p0 !== 6'd52) begin n_bad++; $display("FAIL wrap_head_preg: got %0d want 52", p0); end
    cyc();
  endtask

  task automatic test_mispred_flush();
    do_reset();
    set_dp(2, 1, 20); cyc();
    set_dp(2, 3, 22); cyc(); idle();
    set_cdb(2'b11, 2, 3, 2'b00); cyc();
    set_cdb(2'b11, 0, 1, 2'b10); cyc(); idle();
    n_cmp++; if (rt_valid !== 2'b11) begin n_bad++; $display("FAIL mp_rt: got %b want 11", rt_valid); end
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL mp_flush: got %b want 1", flush); end
    n_cmp++; if (rt_preg !== {6'd21, 6'd20}) begin n_bad++; $display("FAIL mp_preg: got %h want %h", rt_preg, {6'd21, 6'd20}); end
    set_dp(2, 5, 40); cyc(); idle();
    n_cmp++; if (dp_free !== 5'd16) begin n_bad++; $display("FAIL mp_free: got %0d want 16", dp_free); end
    n_cmp++; if (rt_valid !== 2'b00 || flush !== 1'b0) begin n_bad++; $display("FAIL mp_after: got rt=%b fl=%b want 00/0", rt_valid, flush); end
    n_cmp++; if (dp_rob_idx !== 8'h10) begin n_bad++; $display("FAIL mp_idx: got %h want 10", dp_rob_idx); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 5; i++) begin set_dp(2, i, 2*i); cyc(); end
    idle();
    set_cdb(2'b11, 0, 1, 2'b00); cyc(); idle();
    n_cmp++; if (rt_valid !== 2'b11) begin n_bad++; $display("FAIL mid_pre_rt: got %b want 11", rt_valid); end
    rst_n = 1'b0; set_cdb(2'b11, 2, 3, 2'b00); set_dp(2, 0, 60); #1;
    n_cmp++; if (rt_valid !== 2'b00 || flush !== 1'b0) begin n_bad++; $display("FAIL mid_during: got rt=%b fl=%b want 00/0", rt_valid, flush); end
    cyc();
    n_cmp++; if (dp_free !== 5'd16) begin n_bad++; $display("FAIL mid_free: got %0d want 16", dp_free); end
    n_cmp++; if (dp_rob_idx !== 8'h10) begin n_bad++; $display("FAIL mid_idx: got %h want 10", dp_rob_idx); end
    rst_n = 1'b1; idle(); set_dp(2, 0, 1); cyc(); idle(); cyc();
    n_cmp++; if (rt_valid !== 2'b00) begin n_bad++; $display("FAIL mid_cdb_ignored: got %b want 00", rt_valid); end
    n_cmp++; if (dp_free !== 5'd14) begin n_bad++; $display("FAIL mid_free_after: got %0d want 14", dp_free); end
  endtask

  task automatic test_random();
    int cand[$];
    int ci[W];
    logic [W-1:0] cv, cm;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      model_expect();
      n_cmp++; if (rt_valid !== exp_rt) begin n_bad++; $display("FAIL rnd_rt c=%0d: got %b want %b", c, rt_valid, exp_rt); end
      n_cmp++; if (flush !== exp_flush) begin n_bad++; $display("FAIL rnd_flush c=%0d: got %b want %b", c, flush, exp_flush); end
      n_cmp++; if (dp_free !== (IW+1)'(exp_free)) begin n_bad++; $display("FAIL rnd_free c=%0d: got %0d want %0d", c, dp_free, exp_free); end
      n_cmp++; if (dp_rob_idx !== exp_idx) begin n_bad++; $display("FAIL rnd_idx c=%0d: got %h want %h", c, dp_rob_idx, exp_idx); end
      for (int k = 0; k < int'(W); k++) begin
        if (exp_rt[k]) begin
          n_cmp++;
          if (rt_areg[k*AW +: AW] !== exp_areg[k*AW +: AW] || rt_preg[k*PW +: PW] !== exp_preg[k*PW +: PW] ||
              rt_told[k*PW +: PW] !== exp_told[k*PW +: PW]) begin
            n_bad++;
            $display("FAIL rnd_fields c=%0d way=%0d: got %h/%h/%h want %h/%h/%h", c, k,
                     rt_areg[k*AW +: AW], rt_preg[k*PW +: PW], rt_told[k*PW +: PW],
                     exp_areg[k*AW +: AW], exp_preg[k*PW +: PW], exp_told[k*PW +: PW]);
          end
        end
      end
      set_dp($urandom_range(0, (exp_free < int'(W)) ? exp_free : int'(W)), $urandom, $urandom);
      cand = {};
      foreach (mq[i]) if (!mq[i].e.flags.complete) cand.push_back(mq[i].idx);
      cv = '0; cm = '0;
      for (int w = 0; w < int'(W); w++) begin
        ci[w] = 0;
        if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
          int j;
          j = $urandom_range(0, cand.size() - 1);
          ci[w] = cand[j]; cand.delete(j);
          cv[w] = 1'b1; cm[w] = ($urandom_range(0, 11) == 0);
        end else if (mq.size() < int'(ROB) && $urandom_range(0, 5) == 0) begin
          ci[w] = m_tail; cv[w] = 1'b1; cm[w] = 1'($urandom);
        end
      end
      set_cdb(cv, ci[0], ci[1], cm);
      cyc();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_dispatch();
    test_ooo_complete();
    test_full();
    test_wrap();
    test_mispred_flush();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rob_nway.md
ROB_NWAY -- requirements
Module: rob_nway

Interface
REQ-001 Parameter ROB_SIZE, 16, entry count; power of two, at least 2*WAYS.
REQ-002 Parameter WAYS, 2, dispatch, complete and retire width per cycle (1..4).
REQ-003 Parameter AREG_W, 5, architectural register index width.
REQ-004 Parameter PREG_W, 6, physical register tag width; IDX_W = $clog2(ROB_SIZE).
REQ-005 clock  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 dp_valid  in  WAYS  dispatch request per way; set bits contiguous from bit 0.
REQ-008 dp_areg / dp_preg / dp_told  in  WAYS*AREG_W / WAYS*PREG_W / WAYS*PREG_W  dest arch reg, new tag, previous tag.
REQ-009 dp_free  out  IDX_W+1  free entry count, registered.
REQ-010 dp_rob_idx  out  WAYS*IDX_W  index allocated to way k: (tail+k) mod ROB_SIZE.
REQ-011 cdb_valid / cdb_rob_idx / cdb_mispred  in  WAYS / WAYS*IDX_W / WAYS  completion broadcast per way.
REQ-012 rt_valid  out  WAYS  retire per way, contiguous from bit 0.
REQ-013 rt_areg / rt_preg / rt_told  out  per-way fields of retiring entries.
REQ-014 flush  out  1  mispredicted head-side entry retiring this cycle.

Function
REQ-015 Entry holds valid, complete, mispred, areg, preg, told; head, tail, count registered.
REQ-016 Dispatch: ways with dp_valid written at (tail+k) mod ROB_SIZE, complete=0; tail += popcount(dp_valid), wrapping.
REQ-017 Dispatcher never asserts more ways than min(dp_free, WAYS); excess ways dropped and flagged by simulation assertion; no state corruption.
REQ-018 dp_free excludes slots freed by same-cycle retirement (one-cycle reuse latency).
REQ-019 Completion: each cdb_valid way sets complete and ORs cdb_mispred into the indexed valid entry; completion to an invalid entry ignored.
REQ-020 Retire is combinational from registered state: way k retires iff entry head+k valid, complete, and ways 0..k-1 retire without mispred.
REQ-021 A retiring entry with mispred asserts flush; no younger way retires that cycle.
REQ-022 Completion and retirement of the same entry in one cycle impossible; completion visible to retire the next cycle (CDB at edge M, rt_valid in cycle after M).
REQ-023 head += popcount(rt_valid), wrapping; count += dispatched - retired.
REQ-024 Flush: same-cycle dispatch ignored; next cycle all entries invalid, head=tail=0, count=0, dp_free=ROB_SIZE.
REQ-025 Full (count=ROB_SIZE): dp_free=0; empty: rt_valid=0, flush=0.
REQ-026 Pointer wrap: indices modulo ROB_SIZE with no gap; multi-way dispatch/retire may straddle the wrap.

Reset
REQ-027 reset low at an edge: all entries invalid, head=tail=count=0, regardless of in-flight operations.
REQ-028 During/after reset: rt_valid=0, flush=0, dp_free=ROB_SIZE, dp_rob_idx way k = k.
REQ-029 Dispatch and CDB inputs ignored in any cycle reset is low.

Structure
REQ-030 Package rob_pkg holds ROB_ENTRY typedef, default parameter constants, and dispatch/CDB/retire packet typedefs.
REQ-031 Sub-module rob_retire_sel: WAYS-wide prefix chain producing rt_valid and flush from head-window entries.
REQ-032 RTL 120-400 lines; no latches; all state in one always_ff with synchronous reset.

Verification
REQ-033 Reset, then dispatch 2 ways (areg 3,4; preg 33,34) -> dp_rob_idx {0,1}; dp_free 16 then 14.
REQ-034 CDB idx1 then idx0 -> no retire after idx1 alone; both retire same cycle after idx0, rt_preg {33,34}.
REQ-035 Fill to 16 -> dp_free=0; extra dp_valid dropped, assertion fires; retire 2 -> dp_free=2 one cycle later.
REQ-036 head=15, two entries at 15 and 0 complete -> both retire in one cycle; head becomes 1.
REQ-037 Entries 0..3 complete, entry 1 mispred -> rt_valid=2'b11 with flush=1; next cycle count=0, dp_free=16.
REQ-038 reset low mid-stream with 10 entries and active CDB -> next cycle dp_free=16, rt_valid=0, CDB ignored.
